// File: rtl/clk_gate_en_ctrl_if.sv
// Clock-gate enable control interface.
// Groups the request/configuration inputs and the status outputs of
// clk_gate_en_ctrl. The master modport drives the requests and configuration.
// The slave modport is the controller.
//
// Handshake: all signals are levels. There is no valid/ready pulse pair.
// wake_req is raised by the requester and must be held until clk_ready=1,
// because clk_ready=1 is the only promise that the gated clock is toggling.
// busy_req and cfg_gate_dis are sampled every cycle. While either is 1,
// gating is blocked, or an active gate is ended.
interface clk_gate_en_ctrl_if;
  logic        busy_req;
  logic        wake_req;
  logic        cfg_gate_dis;
  logic [7:0]  cfg_idle_thresh;
  logic        external_en;
  logic        clk_ready;
  logic [1:0]  gate_state;
  logic [15:0] gated_cyc_cnt;

  modport master (
    output busy_req,
    output wake_req,
    output cfg_gate_dis,
    output cfg_idle_thresh,
    input  external_en,
    input  clk_ready,
    input  gate_state,
    input  gated_cyc_cnt
  );

  modport slave (
    input  busy_req,
    input  wake_req,
    input  cfg_gate_dis,
    input  cfg_idle_thresh,
    output external_en,
    output clk_ready,
    output gate_state,
    output gated_cyc_cnt
  );
endinterface

// File: rtl/clk_gate_en_ctrl.sv
// clk_gate_en_ctrl: idle-driven clock gating controller.
// The controller counts idle cycles. When the count reaches the threshold,
// it drops the gated clock cell enable. Any busy, wake or disable request
// brings the clock back through a one-cycle WAKE state. That WAKE cycle
// covers the enable latch latency of the gated cell.
// Optional feature: define CLK_GATE_STAT_EN to build a saturating counter
// of cycles spent in GATED. Without the macro, gated_cyc_cnt reads 0.
// All outputs are flops. There is no combinational path from any input
// to any output.
module clk_gate_en_ctrl (
  input  logic                forever_cpuclk,
  input  logic                cpurst_b,
  clk_gate_en_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    IDLE  = 2'b01,
    GATED = 2'b10,
    WAKE  = 2'b11
  } gate_state_e;

  gate_state_e state;
  gate_state_e state_nxt;
  logic [7:0]  idle_cnt;
  logic        ext_en_q;
  logic        clk_rdy_q;
  logic        wake_cond;

  // Any of these ends idling or gating immediately.
  assign wake_cond = bus.busy_req | bus.wake_req | bus.cfg_gate_dis;

  // Next-state decode. In IDLE, a request has priority over a threshold hit.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (!wake_cond) state_nxt = IDLE;
      IDLE: begin
        if (wake_cond)                            state_nxt = RUN;
        else if (idle_cnt >= bus.cfg_idle_thresh) state_nxt = GATED;
      end
      GATED:   if (wake_cond) state_nxt = WAKE;
      WAKE:    state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // FSM, idle counter and the enable/ready flops, all registered from next state.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state     <= RUN;
      idle_cnt  <= 8'h00;
      ext_en_q  <= 1'b1;
      clk_rdy_q <= 1'b1;
    end else begin
      state     <= state_nxt;
      ext_en_q  <= (state_nxt != GATED);
      clk_rdy_q <= (state_nxt == RUN) || (state_nxt == IDLE);
      if (state == RUN) begin
        idle_cnt <= 8'h00;
      end else if (state == IDLE && state_nxt == IDLE && idle_cnt != 8'hFF) begin
        idle_cnt <= idle_cnt + 8'd1;
      end
    end
  end

  assign bus.external_en = ext_en_q;
  assign bus.clk_ready   = clk_rdy_q;
  assign bus.gate_state  = state;

`ifdef CLK_GATE_STAT_EN
  logic [15:0] stat_cnt;

  // Saturating count of cycles spent in GATED. Only reset clears it.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      stat_cnt <= 16'h0000;
    end else if (state == GATED && stat_cnt != 16'hFFFF) begin
      stat_cnt <= stat_cnt + 16'd1;
    end
  end

  assign bus.gated_cyc_cnt = stat_cnt;
`else
  assign bus.gated_cyc_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_clk_gate_en_ctrl.sv
// Bench for clk_gate_en_ctrl.
// Uses a vector table of per-cycle inputs and expected outputs.
// Hand-written sequences cover reset in GATED, the long disable hold and
// the statistic counter. Expected outputs are pushed into exp_q when the
// stimulus is driven, then popped and compared after the clock edge.
module tb_clk_gate_en_ctrl;

  localparam logic [1:0] S_RUN   = 2'b00;
  localparam logic [1:0] S_IDLE  = 2'b01;
  localparam logic [1:0] S_GATED = 2'b10;
  localparam logic [1:0] S_WAKE  = 2'b11;

  logic forever_cpuclk;
  logic cpurst_b;

  clk_gate_en_ctrl_if bus_if ();

  clk_gate_en_ctrl dut (
    .forever_cpuclk (forever_cpuclk),
    .cpurst_b       (cpurst_b),
    .bus            (bus_if)
  );

  typedef struct {
    logic       busy;
    logic       wake;
    logic       dis;
    logic [7:0] thresh;
    logic [1:0] st;
    logic       en;
    logic       rdy;
  } vec_t;

  vec_t       vec_q[$];
  logic [3:0] exp_q[$];
  int         checks;
  int         failures;
  logic [15:0] exp_stat_10;
  logic [15:0] exp_stat_11;

  // Clock and reset
  initial begin
    forever_cpuclk = 1'b0;
    forever #5 forever_cpuclk = ~forever_cpuclk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add_vec(input logic b, input logic w, input logic d, input logic [7:0] th,
                         input logic [1:0] st, input logic en, input logic rdy);
    vec_t v;
    v.busy = b; v.wake = w; v.dis = d; v.thresh = th;
    v.st = st; v.en = en; v.rdy = rdy;
    vec_q.push_back(v);
  endtask

  // Driver: apply one cycle of inputs, queue expectation, compare after the edge.
  task automatic step(input string name, input logic b, input logic w, input logic d,
                      input logic [7:0] th, input logic [1:0] st, input logic en,
                      input logic rdy);
    logic [3:0] exp;
    logic [3:0] act;
    @(negedge forever_cpuclk);
    bus_if.busy_req        = b;
    bus_if.wake_req        = w;
    bus_if.cfg_gate_dis    = d;
    bus_if.cfg_idle_thresh = th;
    exp_q.push_back({st, en, rdy});
    @(posedge forever_cpuclk);
    #1;
    if (exp_q.size() == 0) begin
      check({name, "_queue_empty"}, 32'd0, 32'd1);
    end else begin
      exp = exp_q.pop_front();
      act = {bus_if.gate_state, bus_if.external_en, bus_if.clk_ready};
      check(name, {28'd0, act}, {28'd0, exp});
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, {30'd0, bus_if.gate_state}, {30'd0, S_RUN});
    check({tag, "_en"},    {31'd0, bus_if.external_en}, 32'd1);
    check({tag, "_rdy"},   {31'd0, bus_if.clk_ready}, 32'd1);
    check({tag, "_stat"},  {16'd0, bus_if.gated_cyc_cnt}, 32'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
`ifdef CLK_GATE_STAT_EN
    exp_stat_10 = 16'd10;
    exp_stat_11 = 16'd11;
`else
    exp_stat_10 = 16'd0;
    exp_stat_11 = 16'd0;
`endif

    // Vector table. Each row is the input held before an edge and the
    // outputs expected after that edge.
    add_vec(1, 0, 0, 8'd3, S_RUN,   1, 1);
    add_vec(0, 0, 0, 8'd3, S_IDLE,  1, 1); // idle count 0
    add_vec(0, 0, 0, 8'd3, S_IDLE,  1, 1); // 1
    add_vec(0, 0, 0, 8'd3, S_IDLE,  1, 1); // 2
    add_vec(0, 0, 0, 8'd3, S_IDLE,  1, 1); // 3: four IDLE cycles
    add_vec(0, 0, 0, 8'd3, S_GATED, 0, 0);
    add_vec(0, 0, 0, 8'd3, S_GATED, 0, 0);
    add_vec(0, 1, 0, 8'd3, S_WAKE,  1, 0); // en after 1 edge
    add_vec(0, 1, 0, 8'd3, S_RUN,   1, 1); // ready after 2 edges
    add_vec(0, 0, 0, 8'd3, S_IDLE,  1, 1);
    add_vec(0, 0, 0, 8'd3, S_IDLE,  1, 1);
    add_vec(0, 0, 0, 8'd3, S_IDLE,  1, 1);
    add_vec(1, 0, 0, 8'd3, S_RUN,   1, 1); // busy pulse on 3rd IDLE cycle
    add_vec(0, 0, 0, 8'd0, S_IDLE,  1, 1);
    add_vec(0, 0, 0, 8'd0, S_GATED, 0, 0); // thresh 0: exactly one IDLE cycle
    add_vec(0, 0, 1, 8'd0, S_WAKE,  1, 0); // disable while GATED
    add_vec(0, 0, 1, 8'd0, S_RUN,   1, 1);
    add_vec(0, 0, 1, 8'd0, S_RUN,   1, 1);
    add_vec(0, 0, 0, 8'd5, S_IDLE,  1, 1);
    add_vec(0, 0, 0, 8'd5, S_IDLE,  1, 1); // count becomes 1
    add_vec(0, 0, 0, 8'd1, S_GATED, 0, 0); // lowered threshold takes effect
    add_vec(1, 0, 0, 8'd1, S_WAKE,  1, 0);
    add_vec(0, 0, 0, 8'd1, S_RUN,   1, 1); // WAKE -> RUN unconditionally
    add_vec(0, 0, 0, 8'd1, S_IDLE,  1, 1);
    add_vec(0, 1, 1, 8'd1, S_RUN,   1, 1);
    add_vec(0, 0, 0, 8'd0, S_IDLE,  1, 1);
    add_vec(1, 0, 0, 8'd0, S_RUN,   1, 1); // request beats threshold hit
    add_vec(0, 0, 0, 8'd0, S_IDLE,  1, 1);
    add_vec(0, 0, 0, 8'd0, S_GATED, 0, 0);
    add_vec(0, 0, 0, 8'd0, S_GATED, 0, 0);
    add_vec(1, 0, 0, 8'd0, S_WAKE,  1, 0);
    add_vec(1, 0, 0, 8'd0, S_RUN,   1, 1);
    add_vec(1, 0, 0, 8'd0, S_RUN,   1, 1);

    // Reset
    cpurst_b               = 1'b0;
    bus_if.busy_req        = 1'b1;
    bus_if.wake_req        = 1'b0;
    bus_if.cfg_gate_dis    = 1'b0;
    bus_if.cfg_idle_thresh = 8'd3;
    #12;
    check_reset_outputs("reset");
    @(negedge forever_cpuclk);
    cpurst_b = 1'b1;

    // Table-driven section
    for (int i = 0; i < vec_q.size(); i++) begin
      step($sformatf("vec%0d", i), vec_q[i].busy, vec_q[i].wake, vec_q[i].dis,
           vec_q[i].thresh, vec_q[i].st, vec_q[i].en, vec_q[i].rdy);
    end

    // Reset pulsed mid-GATED: the clock comes back without an edge.
    step("rg_idle",  0, 0, 0, 8'd0, S_IDLE,  1, 1);
    step("rg_gate",  0, 0, 0, 8'd0, S_GATED, 0, 0);
    step("rg_gate2", 0, 0, 0, 8'd0, S_GATED, 0, 0);
    @(negedge forever_cpuclk);
    #2;
    bus_if.busy_req = 1'b1;
    cpurst_b = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(negedge forever_cpuclk);
    cpurst_b = 1'b1;
    step("rg_resume", 1, 0, 0, 8'd0, S_RUN, 1, 1);

    // A long disable hold keeps the block running.
    for (int i = 0; i < 300; i++) begin
      step("dis_hold", 0, 0, 1, 8'd0, S_RUN, 1, 1);
    end
    step("dis_idle", 0, 0, 0, 8'd0, S_IDLE,  1, 1);
    step("dis_gate", 0, 0, 0, 8'd0, S_GATED, 0, 0);
    step("dis_wake", 0, 0, 1, 8'd0, S_WAKE,  1, 0);
    step("dis_run",  0, 0, 1, 8'd0, S_RUN,   1, 1);

    // Gated-cycle statistic: fresh reset, then 10 cycles in GATED.
    @(negedge forever_cpuclk);
    bus_if.busy_req = 1'b1;
    cpurst_b = 1'b0;
    #1;
    check_reset_outputs("stat_rst");
    @(negedge forever_cpuclk);
    cpurst_b = 1'b1;
    step("st_idle", 0, 0, 0, 8'd0, S_IDLE,  1, 1);
    step("st_gate", 0, 0, 0, 8'd0, S_GATED, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step("st_hold", 0, 0, 0, 8'd0, S_GATED, 0, 0);
    end
    check("stat_10", {16'd0, bus_if.gated_cyc_cnt}, {16'd0, exp_stat_10});
    step("st_wake", 0, 1, 0, 8'd0, S_WAKE, 1, 0);
    step("st_run",  0, 1, 0, 8'd0, S_RUN,  1, 1);
    check("stat_hold", {16'd0, bus_if.gated_cyc_cnt}, {16'd0, exp_stat_11});

    check("exp_q_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
